// File: rtl/sap1_control_sequencer_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state encoding and control-word bit
// positions. The datapath top level uses the same bit indices to unpack the
// control word.
package sap1_pkg;

  // One value per T-state of the instruction cycle.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // Opcodes 0x9..0xD are unassigned and run as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit positions inside the control word.
  localparam int CW_PC_OUT     = 0;
  localparam int CW_PC_INC     = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_RAM_OUT    = 4;
  localparam int CW_RAM_IN     = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OUT     = 7;
  localparam int CW_A_LOAD     = 8;
  localparam int CW_A_OUT      = 9;
  localparam int CW_B_LOAD     = 10;
  localparam int CW_ALU_OUT    = 11;
  localparam int CW_ALU_SUB    = 12;
  localparam int CW_FLAGS_LOAD = 13;
  localparam int CW_OUT_LOAD   = 14;
  localparam int CW_WIDTH      = 15;

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  // Control word with only the given line asserted.
  function automatic ctrl_word_t cw_bit(input int idx);
    return ctrl_word_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// Bundle between the control sequencer and the SAP-1 datapath: IR contents and
// flags flow in, one-hot control lines, halt and debug step flow out.
interface sap1_control_sequencer_if #(
  parameter int INSTR_WIDTH = 8
);

  logic [INSTR_WIDTH-1:0] i_instruction;
  logic                   i_flag_carry;
  logic                   i_flag_zero;

  logic o_pc_out;
  logic o_pc_inc;
  logic o_pc_load;
  logic o_mar_load;
  logic o_ram_out;
  logic o_ram_in;
  logic o_ir_load;
  logic o_ir_out;
  logic o_a_load;
  logic o_a_out;
  logic o_b_load;
  logic o_alu_out;
  logic o_alu_sub;
  logic o_flags_load;
  logic o_out_load;
  logic o_halt;
  logic [2:0] o_step;

  // Sequencer side.
  modport master (
    input  i_instruction, i_flag_carry, i_flag_zero,
    output o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_in,
           o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_out,
           o_alu_sub, o_flags_load, o_out_load, o_halt, o_step
  );

  // Datapath side.
  modport slave (
    output i_instruction, i_flag_carry, i_flag_zero,
    input  o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_in,
           o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_out,
           o_alu_sub, o_flags_load, o_out_load, o_halt, o_step
  );

endinterface

// File: rtl/sap1_control_sequencer_decode.sv
// Combinational microcode ROM for SAP-1: maps (step, opcode, flags) to the
// control word, flags the opcode's final T-state and requests halt for HLT.
import sap1_pkg::*;

module sap1_microcode_decode #(
  parameter int OPCODE_WIDTH = 4
) (
  input  step_e                   i_step,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_flag_carry,
  input  logic                    i_flag_zero,
  output ctrl_word_t              o_ctrl,
  output logic                    o_last,
  output logic                    o_halt_req
);

  logic [3:0] w_op;
  step_e      w_lastStep;

  assign w_op = 4'(i_opcode);

  // Microcode table; anything not listed leaves every line low.
  always_comb begin
    o_ctrl     = '0;
    o_halt_req = 1'b0;
    w_lastStep = T2;

    case (w_op)
      OP_LDA, OP_STA: w_lastStep = T3;
      OP_ADD, OP_SUB: w_lastStep = T4;
      default:        w_lastStep = T2;
    endcase

    case (i_step)
      T0: o_ctrl = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
      T1: o_ctrl = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
      T2: begin
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            o_ctrl = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
          OP_LDI: o_ctrl = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
          OP_JMP: o_ctrl = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
          OP_JC: begin
            if (i_flag_carry) o_ctrl = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
          end
          OP_JZ: begin
            if (i_flag_zero) o_ctrl = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
          end
          OP_OUT: o_ctrl = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
          OP_HLT: o_halt_req = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        case (w_op)
          OP_LDA:         o_ctrl = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
          OP_ADD, OP_SUB: o_ctrl = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
          OP_STA:         o_ctrl = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_IN);
          default: ;
        endcase
      end
      T4: begin
        case (w_op)
          OP_ADD: o_ctrl = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_FLAGS_LOAD);
          OP_SUB: o_ctrl = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_FLAGS_LOAD)
                         | cw_bit(CW_ALU_SUB);
          default: ;
        endcase
      end
      default: ;
    endcase

    // Treating any step at or past the final one as final also pulls
    // unreachable encodings back to T0.
    o_last = (i_step >= w_lastStep);
  end

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T-state counter and halt latch around the
// microcode decoder. Control lines are forced low once halted.
import sap1_pkg::*;

module sap1_control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int INSTR_WIDTH  = 8
) (
  input  logic                        mclk,
  input  logic                        mrst_n,
  input  logic                        mclk_en,
  sap1_control_sequencer_if.master    bus
);

  step_e      r_step;
  logic       r_halt;
  step_e      w_nextStep;
  logic       w_nextHalt;
  ctrl_word_t w_decCtrl;
  ctrl_word_t w_ctrl;
  logic       w_last;
  logic       w_haltReq;
  logic [OPCODE_WIDTH-1:0] w_opcode;

  assign w_opcode = bus.i_instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];

  sap1_microcode_decode #(
    .OPCODE_WIDTH (OPCODE_WIDTH)
  ) u_decode (
    .i_step       (r_step),
    .i_opcode     (w_opcode),
    .i_flag_carry (bus.i_flag_carry),
    .i_flag_zero  (bus.i_flag_zero),
    .o_ctrl       (w_decCtrl),
    .o_last       (w_last),
    .o_halt_req   (w_haltReq)
  );

  // Step and halt registers; reset drops straight back to T0, not halted.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_step <= T0;
      r_halt <= 1'b0;
    end else begin
      r_step <= w_nextStep;
      r_halt <= w_nextHalt;
    end
  end

  // Advance one T-state per enable; once halted nothing moves until reset.
  always_comb begin
    w_nextStep = r_step;
    w_nextHalt = r_halt;
    if (mclk_en && !r_halt) begin
      if (w_last) w_nextStep = T0;
      else        w_nextStep = step_e'(r_step + 3'd1);
      if (w_haltReq) w_nextHalt = 1'b1;
    end
  end

  assign w_ctrl = r_halt ? '0 : w_decCtrl;

  assign bus.o_pc_out     = w_ctrl[CW_PC_OUT];
  assign bus.o_pc_inc     = w_ctrl[CW_PC_INC];
  assign bus.o_pc_load    = w_ctrl[CW_PC_LOAD];
  assign bus.o_mar_load   = w_ctrl[CW_MAR_LOAD];
  assign bus.o_ram_out    = w_ctrl[CW_RAM_OUT];
  assign bus.o_ram_in     = w_ctrl[CW_RAM_IN];
  assign bus.o_ir_load    = w_ctrl[CW_IR_LOAD];
  assign bus.o_ir_out     = w_ctrl[CW_IR_OUT];
  assign bus.o_a_load     = w_ctrl[CW_A_LOAD];
  assign bus.o_a_out      = w_ctrl[CW_A_OUT];
  assign bus.o_b_load     = w_ctrl[CW_B_LOAD];
  assign bus.o_alu_out    = w_ctrl[CW_ALU_OUT];
  assign bus.o_alu_sub    = w_ctrl[CW_ALU_SUB];
  assign bus.o_flags_load = w_ctrl[CW_FLAGS_LOAD];
  assign bus.o_out_load   = w_ctrl[CW_OUT_LOAD];
  assign bus.o_halt       = r_halt;
  assign bus.o_step       = r_step;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Testbench for sap1_control_sequencer: directed instruction walks with
// literal expectations, then randomized traffic against a behavioural model.
module tb_sap1_control_sequencer;

  // Bench-local control vector order (msb first):
  // pc_out pc_inc pc_load mar ram_out ram_in ir_load ir_out a_load a_out
  // b_load alu_out alu_sub flags_load out_load
  localparam logic [14:0] M_PC_OUT   = 15'h4000;
  localparam logic [14:0] M_PC_INC   = 15'h2000;
  localparam logic [14:0] M_PC_LOAD  = 15'h1000;
  localparam logic [14:0] M_MAR      = 15'h0800;
  localparam logic [14:0] M_RAM_OUT  = 15'h0400;
  localparam logic [14:0] M_RAM_IN   = 15'h0200;
  localparam logic [14:0] M_IR_LOAD  = 15'h0100;
  localparam logic [14:0] M_IR_OUT   = 15'h0080;
  localparam logic [14:0] M_A_LOAD   = 15'h0040;
  localparam logic [14:0] M_A_OUT    = 15'h0020;
  localparam logic [14:0] M_B_LOAD   = 15'h0010;
  localparam logic [14:0] M_ALU_OUT  = 15'h0008;
  localparam logic [14:0] M_ALU_SUB  = 15'h0004;
  localparam logic [14:0] M_FLAGS    = 15'h0002;
  localparam logic [14:0] M_OUT_LOAD = 15'h0001;

  logic mclk    = 1'b0;
  logic mrst_n  = 1'b0;
  logic mclk_en = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   mStep  = 0;
  logic mHalt  = 1'b0;
  bit   cmpEnable = 1'b0;

  logic [14:0] dutCtrl;

  sap1_control_sequencer_if #(.INSTR_WIDTH(8)) bus ();

  sap1_control_sequencer #(
    .OPCODE_WIDTH (4),
    .INSTR_WIDTH  (8)
  ) dut (
    .mclk    (mclk),
    .mrst_n  (mrst_n),
    .mclk_en (mclk_en),
    .bus     (bus)
  );

  always #5 mclk = ~mclk;

  assign dutCtrl = {bus.o_pc_out, bus.o_pc_inc, bus.o_pc_load, bus.o_mar_load,
                    bus.o_ram_out, bus.o_ram_in, bus.o_ir_load, bus.o_ir_out,
                    bus.o_a_load, bus.o_a_out, bus.o_b_load, bus.o_alu_out,
                    bus.o_alu_sub, bus.o_flags_load, bus.o_out_load};

  // Enabled cycles per instruction, straight from the timing table.
  function automatic int instrLen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Expected control lines for a given opcode / T-state / flags / halt.
  function automatic logic [14:0] modelCtrl(input logic [3:0] op, input int t,
                                            input logic c, input logic z,
                                            input logic h);
    if (h) return 15'h0;
    if (t == 0) return M_PC_OUT | M_MAR;
    if (t == 1) return M_RAM_OUT | M_IR_LOAD | M_PC_INC;
    if (t >= instrLen(op)) return 15'h0;
    case (op)
      4'h1: return (t == 2) ? (M_IR_OUT | M_MAR) : (M_RAM_OUT | M_A_LOAD);
      4'h2, 4'h3: begin
        if (t == 2) return M_IR_OUT | M_MAR;
        if (t == 3) return M_RAM_OUT | M_B_LOAD;
        return M_ALU_OUT | M_A_LOAD | M_FLAGS | ((op == 4'h3) ? M_ALU_SUB : 15'h0);
      end
      4'h4: return (t == 2) ? (M_IR_OUT | M_MAR) : (M_A_OUT | M_RAM_IN);
      4'h5: return M_IR_OUT | M_A_LOAD;
      4'h6: return M_IR_OUT | M_PC_LOAD;
      4'h7: return c ? (M_IR_OUT | M_PC_LOAD) : 15'h0;
      4'h8: return z ? (M_IR_OUT | M_PC_LOAD) : 15'h0;
      4'hE: return M_A_OUT | M_OUT_LOAD;
      default: return 15'h0;
    endcase
  endfunction

  // Reference model of step and halt: count enabled cycles modulo length.
  always @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      mStep <= 0;
      mHalt <= 1'b0;
    end else if (mclk_en && !mHalt) begin
      if (bus.i_instruction[7:4] == 4'hF && mStep == 2) mHalt <= 1'b1;
      mStep <= (mStep + 1 == instrLen(bus.i_instruction[7:4])) ? 0 : mStep + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge mclk) begin
    if (cmpEnable && mrst_n) begin
      checkOutput("model_step", 32'(bus.o_step), 32'(mStep));
      checkOutput("model_halt", 32'(bus.o_halt), 32'(mHalt));
      checkOutput("model_ctrl", 32'(dutCtrl),
                  32'(modelCtrl(bus.i_instruction[7:4], mStep, bus.i_flag_carry,
                                bus.i_flag_zero, mHalt)));
    end
  end

  task automatic applyStimulus(input logic [7:0] instr, input logic en,
                               input logic c, input logic z);
    bus.i_instruction = instr;
    mclk_en           = en;
    bus.i_flag_carry  = c;
    bus.i_flag_zero   = z;
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Run one instruction from T0 to its T2..T4 literal expectations.
  task automatic walkCheck(input string name, input logic [7:0] instr,
                           input logic c, input logic z, input int len,
                           input logic [14:0] e2, input logic [14:0] e3,
                           input logic [14:0] e4);
    applyStimulus(instr, 1'b1, c, z);
    tick();
    checkOutput({name, "_t1"}, 32'(dutCtrl), 32'(M_RAM_OUT | M_IR_LOAD | M_PC_INC));
    tick();
    checkOutput({name, "_t2"}, 32'(dutCtrl), 32'(e2));
    if (len > 3) begin
      tick();
      checkOutput({name, "_t3"}, 32'(dutCtrl), 32'(e3));
    end
    if (len > 4) begin
      tick();
      checkOutput({name, "_t4"}, 32'(dutCtrl), 32'(e4));
    end
    tick();
    checkOutput({name, "_end_step"}, 32'(bus.o_step), 32'd0);
  endtask

  logic [14:0] ldaTab [4];
  int          haltCycles;

  initial begin
    ldaTab[0] = 15'h4800;
    ldaTab[1] = 15'h2500;
    ldaTab[2] = 15'h0880;
    ldaTab[3] = 15'h0440;

    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    mrst_n = 1'b1;
    #1;
    cmpEnable = 1'b1;
    checkOutput("reset_step", 32'(bus.o_step), 32'd0);
    checkOutput("reset_halt", 32'(bus.o_halt), 32'd0);
    checkOutput("reset_ctrl", 32'(dutCtrl), 32'h4800);

    // NOP: step sequence 0,1,2,0.
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("nop_step1", 32'(bus.o_step), 32'd1);
    checkOutput("nop_t1", 32'(dutCtrl), 32'h2500);
    tick();
    checkOutput("nop_step2", 32'(bus.o_step), 32'd2);
    checkOutput("nop_t2", 32'(dutCtrl), 32'h0);
    tick();
    checkOutput("nop_step0", 32'(bus.o_step), 32'd0);

    walkCheck("add", 8'h2F, 1'b0, 1'b0, 5, 15'h0880, 15'h0410, 15'h004A);
    walkCheck("sub", 8'h3F, 1'b0, 1'b0, 5, 15'h0880, 15'h0410, 15'h004E);
    walkCheck("jc0", 8'h73, 1'b0, 1'b1, 3, 15'h0000, 15'h0, 15'h0);
    walkCheck("jc1", 8'h73, 1'b1, 1'b0, 3, 15'h1080, 15'h0, 15'h0);
    walkCheck("jz0", 8'h83, 1'b1, 1'b0, 3, 15'h0000, 15'h0, 15'h0);
    walkCheck("jz1", 8'h83, 1'b0, 1'b1, 3, 15'h1080, 15'h0, 15'h0);
    walkCheck("sta", 8'h45, 1'b0, 1'b0, 4, 15'h0880, 15'h0220, 15'h0);
    walkCheck("out", 8'hE0, 1'b0, 1'b0, 3, 15'h0021, 15'h0, 15'h0);
    walkCheck("undef", 8'hB7, 1'b1, 1'b1, 3, 15'h0000, 15'h0, 15'h0);

    // HLT: halt latches on the edge leaving T2, then everything freezes.
    applyStimulus(8'hF0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("hlt_t2_ctrl", 32'(dutCtrl), 32'h0);
    checkOutput("hlt_t2_halt", 32'(bus.o_halt), 32'd0);
    tick();
    checkOutput("hlt_halt_set", 32'(bus.o_halt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    checkOutput("hlt_frozen_step", 32'(bus.o_step), 32'd0);
    checkOutput("hlt_frozen_ctrl", 32'(dutCtrl), 32'h0);
    mrst_n = 1'b0;
    #1;
    checkOutput("hlt_async_rst_halt", 32'(bus.o_halt), 32'd0);
    checkOutput("hlt_async_rst_step", 32'(bus.o_step), 32'd0);
    mrst_n = 1'b1;

    // LDA with the enable high on one cycle in three.
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 3; j++) begin
        applyStimulus(8'h14, (j == 2), 1'b0, 1'b0);
        tick();
        checkOutput("lda_en_step", 32'(bus.o_step), (j == 2) ? 32'((s + 1) % 4) : 32'(s));
        checkOutput("lda_en_ctrl", 32'(dutCtrl),
                    32'(ldaTab[(j == 2) ? ((s + 1) % 4) : s]));
      end
    end

    // STA interrupted by reset in T3.
    applyStimulus(8'h45, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("sta_t3_ram_in", 32'(bus.o_ram_in), 32'd1);
    mrst_n = 1'b0;
    #1;
    checkOutput("sta_rst_step", 32'(bus.o_step), 32'd0);
    checkOutput("sta_rst_ram_in", 32'(bus.o_ram_in), 32'd0);
    mrst_n = 1'b1;

    // Randomized traffic; the compare process checks every cycle.
    haltCycles = 0;
    for (int n = 0; n < 1500; n++) begin
      tick();
      mclk_en          = ($urandom_range(0, 3) != 0);
      bus.i_flag_carry = 1'($urandom_range(0, 1));
      bus.i_flag_zero  = 1'($urandom_range(0, 1));
      if (mStep == 0) bus.i_instruction = 8'($urandom);
      if (mHalt) haltCycles++;
      if ((mHalt && haltCycles > 4) || $urandom_range(0, 99) == 0) begin
        haltCycles = 0;
        mrst_n = 1'b0;
        #1;
        mrst_n = 1'b1;
      end
    end

    tick();
    cmpEnable = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
